cacheline_mem_arbiter: RTL and testbench

//  Shares one banked burst-memory port (64-bit beats, 4-beat/256-bit lines) between the I-cache (read-only)
//  and D-cache (read/write). Serializes write bursts, issues reads, deserializes returned bursts and routes

---
 rtl/cacheline_mem_arb_pkg.sv | 23 ++
 rtl/mem_burst_collector.sv | 48 ++++
 rtl/cacheline_mem_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_cacheline_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cacheline_mem_arb_pkg.sv
// Shared line geometry and enum types for the I/D-cache burst-memory arbiter.
package cacheline_mem_arb_pkg;

    localparam int BEAT_W    = 64;
    localparam int BURST_LEN = 4;
    localparam int LINE_W    = BEAT_W * BURST_LEN;

    typedef logic [LINE_W-1:0] line_t;
    typedef logic [BEAT_W-1:0] beat_t;

    typedef enum logic [1:0] {
        IDLE,
        RD_ISSUE,
        WR_ISSUE,
        WR_DONE
    } arb_state_t;

    typedef enum logic {
        SRC_I,
        SRC_D
    } req_src_t;

endpackage

// File: rtl/mem_burst_collector.sv
// Deserializes a returning memory burst into one cache line.
// done is combinational with the last beat so the owner can register the line that same edge.
module mem_burst_collector #(
    parameter int ADDR_W    = 32,
    parameter int BEAT_W    = 64,
    parameter int BURST_LEN = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rvalid,
    input  logic [BEAT_W-1:0]           rdata,
    input  logic [ADDR_W-1:0]           raddr,
    output logic [BEAT_W*BURST_LEN-1:0] line,
    output logic [ADDR_W-1:0]           addr,
    output logic                        done
);

    localparam int LINE_W = BEAT_W * BURST_LEN;
    localparam int CNT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);

    logic [CNT_W-1:0]  cnt_p0;
    logic [LINE_W-1:0] line_p0;

    // Beat counter only moves on rvalid, so gaps inside a burst simply stall it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p0 <= '0;
        end else if (rvalid) begin
            cnt_p0 <= (cnt_p0 == LAST) ? '0 : cnt_p0 + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rvalid) begin
            line_p0[cnt_p0*BEAT_W +: BEAT_W] <= rdata;
        end
    end

    always_comb begin
        line = line_p0;
        line[LINE_W-1 -: BEAT_W] = rdata;
    end

    assign addr = raddr;
    assign done = rvalid && (cnt_p0 == LAST);

endmodule

// File: rtl/cacheline_mem_arbiter.sv
// Shares one burst-memory port between the I-cache (reads) and D-cache (reads/writes).
// Define CACHELINE_MEM_ARB_PERF_EN to add saturating read/write/stall counters.
module cacheline_mem_arbiter
    import cacheline_mem_arb_pkg::arb_state_t, cacheline_mem_arb_pkg::IDLE,
           cacheline_mem_arb_pkg::RD_ISSUE, cacheline_mem_arb_pkg::WR_ISSUE,
           cacheline_mem_arb_pkg::WR_DONE, cacheline_mem_arb_pkg::req_src_t,
           cacheline_mem_arb_pkg::SRC_I, cacheline_mem_arb_pkg::SRC_D;
#(
    parameter int ADDR_W    = 32,
    parameter int BEAT_W    = 64,
    parameter int BURST_LEN = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [ADDR_W-1:0]           i_addr,
    input  logic                        i_read,
    output logic [BEAT_W*BURST_LEN-1:0] i_rdata,
    output logic                        i_resp,
    input  logic [ADDR_W-1:0]           d_addr,
    input  logic                        d_read,
    input  logic                        d_write,
    input  logic [BEAT_W*BURST_LEN-1:0] d_wdata,
    output logic [BEAT_W*BURST_LEN-1:0] d_rdata,
    output logic                        d_resp,
    output logic [ADDR_W-1:0]           bmem_addr,
    output logic                        bmem_read,
    output logic                        bmem_write,
    output logic [BEAT_W-1:0]           bmem_wdata,
    input  logic                        bmem_ready,
    input  logic [ADDR_W-1:0]           bmem_raddr,
    input  logic [BEAT_W-1:0]           bmem_rdata,
    input  logic                        bmem_rvalid
`ifdef CACHELINE_MEM_ARB_PERF_EN
    ,
    output logic [31:0]                 perf_rd_cnt,
    output logic [31:0]                 perf_wr_cnt,
    output logic [31:0]                 perf_stall_cnt
`endif
);

    localparam int LINE_W = BEAT_W * BURST_LEN;
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int CNT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFF_W;

    arb_state_t        state;
    req_src_t          rr;
    logic              pend_i;
    logic              pend_d;
    logic              d_is_wr;
    logic [ADDR_W-1:0] addr_i;
    logic [ADDR_W-1:0] addr_d;
    logic [CNT_W-1:0]  beat_cnt;
    logic [CNT_W-1:0]  beat_nxt;

    logic [LINE_W-1:0] col_line;
    logic [ADDR_W-1:0] col_addr;
    logic              col_done;

    logic cand_i;
    logic cand_d;
    logic grant_i;
    logic grant_d;
    logic hit_i;
    logic hit_d;

    mem_burst_collector #(
        .ADDR_W    (ADDR_W),
        .BEAT_W    (BEAT_W),
        .BURST_LEN (BURST_LEN)
    ) u_collector (
        .clk    (clk),
        .rst_n  (rst_n),
        .rvalid (bmem_rvalid),
        .rdata  (bmem_rdata),
        .raddr  (bmem_raddr),
        .line   (col_line),
        .addr   (col_addr),
        .done   (col_done)
    );

    // A source stays ineligible from grant until the edge that ends its resp pulse.
    assign cand_i   = i_read && !pend_i;
    assign cand_d   = (d_read || d_write) && !pend_d;
    assign grant_i  = cand_i && (!cand_d || rr == SRC_I);
    assign grant_d  = cand_d && !grant_i;
    assign beat_nxt = beat_cnt + CNT_W'(1);

    assign hit_i = col_done && pend_i && ((col_addr & LINE_MASK) == addr_i);
    assign hit_d = col_done && pend_d && !d_is_wr && ((col_addr & LINE_MASK) == addr_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr         <= SRC_I;
            pend_i     <= 1'b0;
            pend_d     <= 1'b0;
            d_is_wr    <= 1'b0;
            addr_i     <= '0;
            addr_d     <= '0;
            beat_cnt   <= '0;
            bmem_addr  <= '0;
            bmem_read  <= 1'b0;
            bmem_write <= 1'b0;
            bmem_wdata <= '0;
            i_resp     <= 1'b0;
            d_resp     <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            i_resp <= hit_i;
            d_resp <= hit_d;
            if (hit_i) i_rdata <= col_line;
            if (hit_d) d_rdata <= col_line;
            if (i_resp) pend_i <= 1'b0;
            if (d_resp) pend_d <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_i) begin
                        pend_i    <= 1'b1;
                        addr_i    <= i_addr & LINE_MASK;
                        bmem_addr <= i_addr & LINE_MASK;
                        bmem_read <= 1'b1;
                        state     <= RD_ISSUE;
                        if (cand_d) rr <= SRC_D;
                    end else if (grant_d) begin
                        pend_d    <= 1'b1;
                        d_is_wr   <= d_write;
                        addr_d    <= d_addr & LINE_MASK;
                        bmem_addr <= d_addr & LINE_MASK;
                        if (cand_i) rr <= SRC_I;
                        // Simultaneous d_read and d_write is treated as a write.
                        if (d_write) begin
                            bmem_write <= 1'b1;
                            bmem_wdata <= d_wdata[BEAT_W-1:0];
                            beat_cnt   <= '0;
                            state      <= WR_ISSUE;
                        end else begin
                            bmem_read <= 1'b1;
                            state     <= RD_ISSUE;
                        end
                    end
                end
                RD_ISSUE: begin
                    if (bmem_ready) begin
                        bmem_read <= 1'b0;
                        bmem_addr <= '0;
                        state     <= IDLE;
                    end
                end
                WR_ISSUE: begin
                    if (bmem_ready) begin
                        if (beat_cnt == LAST_BEAT) begin
                            bmem_write <= 1'b0;
                            bmem_wdata <= '0;
                            bmem_addr  <= '0;
                            d_resp     <= 1'b1;
                            state      <= WR_DONE;
                        end else begin
                            beat_cnt   <= beat_nxt;
                            bmem_wdata <= d_wdata[beat_nxt*BEAT_W +: BEAT_W];
                        end
                    end
                end
                WR_DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CACHELINE_MEM_ARB_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_rd_cnt    <= '0;
            perf_wr_cnt    <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (bmem_read && bmem_ready)
                perf_rd_cnt <= sat_inc(perf_rd_cnt);
            if (state == WR_ISSUE && bmem_ready && beat_cnt == LAST_BEAT)
                perf_wr_cnt <= sat_inc(perf_wr_cnt);
            if ((bmem_read || bmem_write) && !bmem_ready)
                perf_stall_cnt <= sat_inc(perf_stall_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// Directed bench for cacheline_mem_arbiter: issue, write serialization, return routing, reset.
module tb_cacheline_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  i_addr;
    logic         i_read;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic [31:0]  d_addr;
    logic         d_read;
    logic         d_write;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] wlog [16];
    int          wn      = 0;
    int          dresp_n = 0;

    logic [255:0] w2;
    logic [255:0] w6;
    logic [255:0] l1;
    logic [255:0] l4;

    cacheline_mem_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_addr      (i_addr),
        .i_read      (i_read),
        .i_rdata     (i_rdata),
        .i_resp      (i_resp),
        .d_addr      (d_addr),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_resp      (d_resp),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
    );

    always #5 clk = ~clk;

    // Accepted write beats and d_resp pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (bmem_write && bmem_ready && wn < 16) begin
            wlog[wn] = bmem_wdata;
            wn = wn + 1;
        end
        if (d_resp) dresp_n = dresp_n + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests = n_tests + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic burst(input logic [31:0] a, input logic [255:0] line, input int gap_at);
        for (int k = 0; k < 4; k++) begin
            if (k == gap_at) begin
                bmem_rvalid = 1'b0;
                tick();
                tick();
            end
            bmem_raddr  = a;
            bmem_rdata  = line[k*64 +: 64];
            bmem_rvalid = 1'b1;
            tick();
        end
        bmem_rvalid = 1'b0;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
    endtask

    // Both caches request in the same cycle; returns come back D first, then I.
    task automatic dual_read(input string tag, input logic [31:0] ia, input logic [31:0] da,
                             input bit i_first);
        logic [255:0] il;
        logic [255:0] dl;
        il = {64'h1111_0000_0000_0004 + 64'(ia), 64'h1111_0000_0000_0003,
              64'h1111_0000_0000_0002, 64'h1111_0000_0000_0001};
        dl = {64'h2222_0000_0000_0004 + 64'(da), 64'h2222_0000_0000_0003,
              64'h2222_0000_0000_0002, 64'h2222_0000_0000_0001};
        i_addr = ia; d_addr = da; i_read = 1'b1; d_read = 1'b1;
        tick();
        chk({tag, "_cmd1_rd"}, 256'(bmem_read), 256'd1);
        chk({tag, "_cmd1_addr"}, 256'(bmem_addr), 256'(i_first ? ia : da));
        tick();
        chk({tag, "_cmd1_done"}, 256'(bmem_read), 256'd0);
        tick();
        chk({tag, "_cmd2_addr"}, 256'(bmem_addr), 256'(i_first ? da : ia));
        tick();
        burst(da, dl, -1);
        chk({tag, "_d_resp"}, 256'({d_resp, i_resp}), 256'b10);
        chk({tag, "_d_rdata"}, d_rdata, dl);
        d_read = 1'b0;
        tick();
        burst(ia, il, -1);
        chk({tag, "_i_resp"}, 256'({i_resp, d_resp}), 256'b10);
        chk({tag, "_i_rdata"}, i_rdata, il);
        i_read = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; i_addr = '0; i_read = 1'b0; d_addr = '0; d_read = 1'b0;
        d_write = 1'b0; d_wdata = '0; bmem_ready = 1'b1; bmem_raddr = '0;
        bmem_rdata = '0; bmem_rvalid = 1'b0;
        tick();
        tick();
        chk("rst_bus", 256'({bmem_read, bmem_write, bmem_addr, bmem_wdata}), 256'd0);
        chk("rst_resp", 256'({i_resp, d_resp}), 256'd0);
        chk("rst_rdata", i_rdata | d_rdata, 256'd0);
        rst_n = 1'b1;
        tick();

        // 1: single I read, burst returns 10 cycles later.
        l1 = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
              64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        i_addr = 32'h0000_1000; i_read = 1'b1;
        chk("t1_no_early_cmd", 256'(bmem_read), 256'd0);
        tick();
        chk("t1_cmd", 256'({bmem_read, bmem_addr}), 256'({1'b1, 32'h0000_1000}));
        tick();
        chk("t1_cmd_drop", 256'(bmem_read), 256'd0);
        repeat (10) tick();
        chk("t1_no_resp_yet", 256'(i_resp), 256'd0);
        burst(32'h0000_1000, l1, -1);
        chk("t1_resp", 256'(i_resp), 256'd1);
        chk("t1_rdata", i_rdata, l1);
        i_read = 1'b0;
        tick();
        chk("t1_resp_pulse", 256'(i_resp), 256'd0);

        // 2: D write with ready low for 3 cycles while beat 2 is presented.
        w2 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        d_addr = 32'h0000_0040; d_wdata = w2; d_write = 1'b1;
        tick();
        chk("t2_cmd", 256'({bmem_write, bmem_addr}), 256'({1'b1, 32'h0000_0040}));
        chk("t2_beat0", 256'(bmem_wdata), 256'(64'h1111_1111_1111_1111));
        tick();
        tick();
        chk("t2_beat2", 256'(bmem_wdata), 256'(64'h3333_3333_3333_3333));
        bmem_ready = 1'b0;
        repeat (3) tick();
        chk("t2_stall_hold", 256'({bmem_write, bmem_wdata}), 256'({1'b1, 64'h3333_3333_3333_3333}));
        chk("t2_stall_no_resp", 256'(d_resp), 256'd0);
        bmem_ready = 1'b1;
        tick();
        chk("t2_beat3", 256'(bmem_wdata), 256'(64'h4444_4444_4444_4444));
        tick();
        chk("t2_resp", 256'({d_resp, bmem_write}), 256'b10);
        d_write = 1'b0;
        tick();
        chk("t2_resp_pulse", 256'(d_resp), 256'd0);
        chk("t2_beat_count", 256'(wn), 256'd4);
        chk("t2_beats", {wlog[3], wlog[2], wlog[1], wlog[0]}, w2);
        chk("t2_resp_once", 256'(dresp_n), 256'd1);

        // 3: simultaneous requests, pointer starts at I.
        dual_read("t3", 32'h0000_0100, 32'h0000_0200, 1'b1);

        // 4: both read the same line; pointer now favours D, then alternates.
        l4 = {64'h0300_0000_0000_0004, 64'h0300_0000_0000_0003,
              64'h0300_0000_0000_0002, 64'h0300_0000_0000_0001};
        i_addr = 32'h0000_0300; d_addr = 32'h0000_0300; i_read = 1'b1; d_read = 1'b1;
        tick();
        chk("t4_cmd1", 256'({bmem_read, bmem_addr}), 256'({1'b1, 32'h0000_0300}));
        tick();
        tick();
        chk("t4_cmd2", 256'({bmem_read, bmem_addr}), 256'({1'b1, 32'h0000_0300}));
        tick();
        burst(32'h0000_0300, l4, -1);
        chk("t4_both_resp", 256'({i_resp, d_resp}), 256'b11);
        chk("t4_i_rdata", i_rdata, l4);
        chk("t4_d_rdata", d_rdata, l4);
        i_read = 1'b0; d_read = 1'b0;
        tick();
        dual_read("t4r2", 32'h0000_0340, 32'h0000_0380, 1'b1);
        dual_read("t4r3", 32'h0000_03C0, 32'h0000_0400, 1'b0);

        // 5: unsolicited burst is dropped; legit burst with a mid-burst gap still routes.
        i_addr = 32'h0000_0500; i_read = 1'b1;
        tick();
        tick();
        burst(32'h0000_09E0, l4, -1);
        chk("t5_unsolicited", 256'({i_resp, d_resp}), 256'd0);
        tick();
        chk("t5_unsolicited_quiet", 256'({i_resp, d_resp, bmem_read, bmem_write}), 256'd0);
        burst(32'h0000_050C, l1, 2);
        chk("t5_gap_resp", 256'(i_resp), 256'd1);
        chk("t5_gap_rdata", i_rdata, l1);
        i_read = 1'b0;
        tick();

        // 6: asynchronous reset while write beat 2 is on the bus.
        w6 = {64'h8888_0000_0000_0004, 64'h8888_0000_0000_0003,
              64'h8888_0000_0000_0002, 64'h8888_0000_0000_0001};
        d_addr = 32'h0000_0080; d_wdata = w6; d_write = 1'b1;
        tick();
        tick();
        tick();
        chk("t6_beat2", 256'({bmem_write, bmem_wdata}), 256'({1'b1, 64'h8888_0000_0000_0003}));
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_bus", 256'({bmem_read, bmem_write, bmem_addr, bmem_wdata}), 256'd0);
        chk("t6_async_resp", 256'({i_resp, d_resp}), 256'd0);
        d_write = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        burst(32'h0000_0080, l4, -1);
        chk("t6_stale_dropped", 256'({i_resp, d_resp}), 256'd0);
        i_addr = 32'h0000_0600; i_read = 1'b1;
        tick();
        chk("t6_post_cmd", 256'({bmem_read, bmem_addr}), 256'({1'b1, 32'h0000_0600}));
        tick();
        burst(32'h0000_0600, w6, -1);
        chk("t6_post_resp", 256'(i_resp), 256'd1);
        chk("t6_post_rdata", i_rdata, w6);
        i_read = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
